// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read port, occupancy count,
// programmable almost-empty/almost-full flags and a sticky overflow/underflow error.
module fifo_param #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic [ADDR_WIDTH:0]   i_almost_empty_th,
    input  logic [ADDR_WIDTH:0]   i_almost_full_th,
    input  logic                  i_error_clr,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_valid_out,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_empty_fifo,
    output logic                  o_full_fifo,
    output logic                  o_almost_empty_fifo,
    output logic                  o_almost_full_fifo,
    output logic                  o_overflow,
    output logic                  o_underflow,
    output logic                  o_error
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1_C = CW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_empty;
    logic                  r_almost_full;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_error;

    logic                  w_is_empty;
    logic                  w_is_full;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_overflow;
    logic                  w_underflow;
    logic [CW-1:0]         w_count_next;
    logic                  w_empty_next;
    logic                  w_full_next;
    logic                  w_almost_empty_next;
    logic                  w_almost_full_next;
    logic                  w_error_next;

    // Accept decisions use the count as it stands at the clock edge.
    always_comb begin
        w_is_empty  = (r_count == '0);
        w_is_full   = (r_count == DEPTH_C);
        w_wr_ok     = i_push & (~w_is_full | i_pop);
        w_rd_ok     = i_pop & ~w_is_empty;
        w_overflow  = i_push & ~w_wr_ok;
        // A push in the same cycle makes an empty-FIFO pop benign.
        w_underflow = i_pop & w_is_empty & ~i_push;
    end

    always_comb begin
        w_count_next = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
        w_empty_next = (w_count_next == '0);
        w_full_next  = (w_count_next == DEPTH_C);
        // A zero threshold leaves the range empty, so the flag stays low.
        w_almost_empty_next = (w_count_next != '0) &&
                              (w_count_next <= i_almost_empty_th);
        // Thresholds at or above DEPTH leave the range empty as well.
        w_almost_full_next  = (w_count_next >= i_almost_full_th) &&
                              (w_count_next <= DEPTH_M1_C);
        w_error_next = (r_error & ~i_error_clr) | w_overflow | w_underflow;
    end

    // Storage is not reset; only pointers and count define its validity.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_rd_ok;
            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_empty <= 1'b0;
            r_almost_full  <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_empty        <= w_empty_next;
            r_full         <= w_full_next;
            r_almost_empty <= w_almost_empty_next;
            r_almost_full  <= w_almost_full_next;
            r_overflow     <= w_overflow;
            r_underflow    <= w_underflow;
            r_error        <= w_error_next;
        end
    end

    assign o_data_out          = r_data_out;
    assign o_valid_out         = r_valid_out;
    assign o_count             = r_count;
    assign o_empty_fifo        = r_empty;
    assign o_full_fifo         = r_full;
    assign o_almost_empty_fifo = r_almost_empty;
    assign o_almost_full_fifo  = r_almost_full;
    assign o_overflow          = r_overflow;
    assign o_underflow         = r_underflow;
    assign o_error             = r_error;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a directed vector table, hand-written corner sequences and
// random traffic checked against a queue-based reference model.
module tb_fifo_param;

    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] din;
    logic [AW:0]   ae_th;
    logic [AW:0]   af_th;
    logic          clr;
    logic [DW-1:0] dout;
    logic          valid;
    logic [AW:0]   count;
    logic          empty_f;
    logic          full_f;
    logic          ae_f;
    logic          af_f;
    logic          ovf;
    logic          unf;
    logic          err;

    fifo_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_push              (push),
        .i_pop               (pop),
        .i_data_in           (din),
        .i_almost_empty_th   (ae_th),
        .i_almost_full_th    (af_th),
        .i_error_clr         (clr),
        .o_data_out          (dout),
        .o_valid_out         (valid),
        .o_count             (count),
        .o_empty_fifo        (empty_f),
        .o_full_fifo         (full_f),
        .o_almost_empty_fifo (ae_f),
        .o_almost_full_fifo  (af_f),
        .o_overflow          (ovf),
        .o_underflow         (unf),
        .o_error             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_q[$];
    int m_dout;
    bit m_valid, m_ovf, m_unf, m_err;

    typedef struct {
        bit push, pop, clr;
        int din;
        int cnt;
        bit valid;
        int dout;
        bit ovf, unf, err, full, empty, ae, af;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit pu, bit po, bit cl, int d, int c, bit v, int o,
                                bit ov, bit un, bit er);
        vec_t r;
        r.push = pu; r.pop = po; r.clr = cl; r.din = d;
        r.cnt = c; r.valid = v; r.dout = o; r.ovf = ov; r.unf = un; r.err = er;
        // Flag expectations for the table run use thresholds ae=2, af=7.
        r.full  = (c == DEPTH);
        r.empty = (c == 0);
        r.ae    = (c >= 1) && (c <= 2);
        r.af    = (c >= 7) && (c <= DEPTH - 1);
        return r;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_q.delete();
        m_dout = 0; m_valid = 0; m_ovf = 0; m_unf = 0; m_err = 0;
    endfunction

    // Model one clock edge from the inputs currently driven.
    function automatic void model_edge();
        int sz;
        bit do_rd, do_wr;
        sz     = m_q.size();
        m_ovf  = push && (sz == DEPTH) && !pop;
        m_unf  = pop && (sz == 0) && !push;
        do_rd  = pop && (sz != 0);
        do_wr  = push && ((sz != DEPTH) || pop);
        m_valid = do_rd;
        if (do_rd) m_dout = m_q.pop_front();
        if (do_wr) m_q.push_back(int'(din));
        m_err = (m_err && !clr) || m_ovf || m_unf;
    endfunction

    task automatic compare_all(string tag);
        int sz;
        sz = m_q.size();
        chk({tag, ".count"}, int'(count), sz);
        chk({tag, ".valid"}, int'(valid), int'(m_valid));
        chk({tag, ".data_out"}, int'(dout), m_dout);
        chk({tag, ".overflow"}, int'(ovf), int'(m_ovf));
        chk({tag, ".underflow"}, int'(unf), int'(m_unf));
        chk({tag, ".error"}, int'(err), int'(m_err));
        chk({tag, ".full"}, int'(full_f), int'(sz == DEPTH));
        chk({tag, ".empty"}, int'(empty_f), int'(sz == 0));
        chk({tag, ".aempty"}, int'(ae_f), int'(sz >= 1 && sz <= int'(ae_th)));
        chk({tag, ".afull"}, int'(af_f), int'(sz >= int'(af_th) && sz <= DEPTH - 1));
    endtask

    task automatic step(string tag, bit pu, bit po, bit cl, int d);
        push = pu; pop = po; clr = cl; din = DW'(d);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        push = 0; pop = 0; clr = 0; din = '0;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        compare_all("reset");
    endtask

    initial begin
        reset = 1'b1; push = 0; pop = 0; clr = 0; din = '0;
        ae_th = 4'd2; af_th = 4'd7;
        #2;

        // Directed table: fill, overflow, drain, underflow, error clear behaviour.
        for (int k = 1; k <= DEPTH; k++) tbl.push_back(mk(1, 0, 0, k, k, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 9, 8, 0, 0, 1, 0, 1));
        for (int j = 1; j <= DEPTH; j++) tbl.push_back(mk(0, 1, 0, 0, 8 - j, 1, j, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 8, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8, 0, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            push = tbl[i].push; pop = tbl[i].pop; clr = tbl[i].clr; din = DW'(tbl[i].din);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d.valid", i), int'(valid), int'(tbl[i].valid));
            chk($sformatf("tbl%0d.data_out", i), int'(dout), tbl[i].dout);
            chk($sformatf("tbl%0d.overflow", i), int'(ovf), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d.underflow", i), int'(unf), int'(tbl[i].unf));
            chk($sformatf("tbl%0d.error", i), int'(err), int'(tbl[i].err));
            chk($sformatf("tbl%0d.full", i), int'(full_f), int'(tbl[i].full));
            chk($sformatf("tbl%0d.empty", i), int'(empty_f), int'(tbl[i].empty));
            chk($sformatf("tbl%0d.aempty", i), int'(ae_f), int'(tbl[i].ae));
            chk($sformatf("tbl%0d.afull", i), int'(af_f), int'(tbl[i].af));
        end

        // Push+pop at full keeps count, emits oldest word, no overflow.
        do_reset();
        for (int k = 0; k < DEPTH; k++) step("fill", 1, 0, 0, 16'h40 + k);
        step("pp_full", 1, 1, 0, 10'h3ff);
        chk("pp_full.count8", int'(count), 8);
        chk("pp_full.oldest", int'(dout), 16'h40);
        chk("pp_full.noovf", int'(ovf), 0);
        for (int k = 0; k < DEPTH; k++) step("drain", 0, 1, 0, 0);
        // Push+pop at empty: only the push happens.
        step("pp_empty", 1, 1, 0, 10'h155);
        chk("pp_empty.count1", int'(count), 1);
        chk("pp_empty.novalid", int'(valid), 0);
        chk("pp_empty.nounf", int'(unf), 0);
        step("pp_empty.pop", 0, 1, 0, 0);
        chk("pp_empty.word", int'(dout), 10'h155);

        // Pointer wrap: several fill/drain rounds of non-power-of-two length.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 7; k++) step("wrap_w", 1, 0, 0, r * 32 + k);
            for (int k = 0; k < 7; k++) step("wrap_r", 0, 1, 0, 0);
        end
        chk("wrap.empty", int'(empty_f), 1);

        // Random traffic with occasional threshold and error-clear activity.
        for (int c = 0; c < 3000; c++) begin
            int bias;
            bias = (c / 200) % 3;
            if (c % 50 == 0) begin
                ae_th = 4'($urandom_range(0, 9));
                af_th = 4'($urandom_range(0, 10));
            end
            step("rand",
                 $urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)),
                 $urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)),
                 $urandom_range(0, 19) == 0,
                 int'($urandom_range(0, 1023)));
        end

        // Asynchronous reset between edges at count 5 with valid_out high.
        do_reset();
        ae_th = 4'd2; af_th = 4'd7;
        for (int k = 0; k < 6; k++) step("pre_rst", 1, 0, 0, k + 1);
        step("pre_rst.pop", 0, 1, 0, 0);
        chk("pre_rst.count5", int'(count), 5);
        push = 0; pop = 0; clr = 0;
        #2;
        reset = 1'b0;
        #1;
        chk("async.count", int'(count), 0);
        chk("async.empty", int'(empty_f), 1);
        chk("async.valid", int'(valid), 0);
        chk("async.data_out", int'(dout), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("post_rst.pop", 0, 1, 0, 0);
        chk("post_rst.underflow", int'(unf), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
